// File: rtl/network_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : network_mul_share_ctrl
// Purpose  : Round-robin sharing of one pipelined 16x10 signed multiplier
//            among NUM_REQ requesters, with requester IDs carried alongside
//            the products in a tag shift register and a valid/ready result
//            port that stalls the multiplier through mul_ce.
// Options  : NETWORK_MUL_SHARE_STATS_EN enables the grant/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module network_mul_share_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [10*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    drain,
  output logic                    idle,
  output logic [15:0]             mul_din0,
  output logic [9:0]              mul_din1,
  output logic                    mul_ce,
  input  logic [25:0]             mul_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [25:0]             res_data,
  output logic [ID_W-1:0]         res_id,
  output logic [31:0]             stat_grants,
  output logic [31:0]             stat_stalls
);

  // Pointer width kept at least 1 so a single-requester build stays legal.
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RR_W-1:0]        rr_q;
  logic [RR_W-1:0]        rr_d;
  logic [MUL_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
  logic [15:0]            din0_q;
  logic [9:0]             din1_q;

  logic                   gnt_any;
  logic [NUM_REQ-1:0]     gnt_oh;
  logic [ID_W-1:0]        gnt_id;
  logic [15:0]            gnt_a;
  logic [9:0]             gnt_b;
  logic                   arb_en;

  // The only reason to stall is a presented result that is not being taken.
  assign mul_ce = !(tag_vld_q[MUL_LATENCY-1] && !res_ready);

  // Reset is included so req_ready reads 0 while reset is held.
  assign arb_en = mul_ce && !drain && !reset;

  // Rotating-priority search starting at rr_q; operands fall back to the
  // held copy so the multiplier inputs do not toggle on bubble cycles.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_a   = din0_q;
    gnt_b   = din1_q;
    rr_d    = rr_q;
    if (arb_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!gnt_any && req_valid[idx]) begin
          gnt_any     = 1'b1;
          gnt_oh[idx] = 1'b1;
          gnt_id      = ID_W'(idx);
          gnt_a       = req_a[16*idx +: 16];
          gnt_b       = req_b[10*idx +: 10];
          rr_d        = (idx + 1 >= NUM_REQ) ? '0 : RR_W'(idx + 1);
        end
      end
    end
  end

  // Pointer, operand hold registers and the ce-qualified tag shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      din0_q    <= '0;
      din1_q    <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      if (gnt_any) begin
        din0_q <= gnt_a;
        din1_q <= gnt_b;
      end
      if (mul_ce) begin
        tag_vld_q[0] <= gnt_any;
        tag_id_q[0]  <= gnt_id;
        for (int s = 1; s < MUL_LATENCY; s++) begin
          tag_vld_q[s] <= tag_vld_q[s-1];
          tag_id_q[s]  <= tag_id_q[s-1];
        end
      end
    end
  end

  assign req_ready = gnt_oh;
  assign mul_din0  = gnt_a;
  assign mul_din1  = gnt_b;
  assign res_valid = tag_vld_q[MUL_LATENCY-1];
  assign res_id    = tag_id_q[MUL_LATENCY-1];
  assign res_data  = mul_dout;
  assign idle      = ~|tag_vld_q;

`ifdef NETWORK_MUL_SHARE_STATS_EN
  logic [31:0] stat_grants_q;
  logic [31:0] stat_stalls_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (gnt_any) begin
        stat_grants_q <= stat_grants_q + 32'd1;
      end
      if (!mul_ce) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_network_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_mul_share_ctrl
// Purpose  : Scoreboard bench for network_mul_share_ctrl with a behavioural
//            2-stage multiplier, a rotating-priority reference model and
//            randomized traffic, back-pressure and drain.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_network_mul_share_ctrl;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_a;
  logic [10*N-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              drain;
  logic              idle;
  logic [15:0]       mul_din0;
  logic [9:0]        mul_din1;
  logic              mul_ce;
  logic [25:0]       mul_dout;
  logic              res_valid;
  logic              res_ready;
  logic [25:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic [31:0]       stat_grants;
  logic [31:0]       stat_stalls;

  typedef struct {
    logic [IDW-1:0] id;
    logic [25:0]    data;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   rr_m    = 0;
  int   n_gnt_m = 0;

  network_mul_share_ctrl #(.NUM_REQ(N), .ID_W(IDW), .MUL_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .drain       (drain),
    .idle        (idle),
    .mul_din0    (mul_din0),
    .mul_din1    (mul_din1),
    .mul_ce      (mul_ce),
    .mul_dout    (mul_dout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_id      (res_id),
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier: two clock-enabled stages, no reset.
  logic signed [25:0] m_s1;
  logic signed [25:0] m_s2;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_s1 <= $signed(mul_din0) * $signed(mul_din1);
      m_s2 <= m_s1;
    end
  end
  assign mul_dout = m_s2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter: predicts stall, the grant, and pushes the product.
  always @(negedge clk) begin : trk
    bit                 ce_exp;
    int                 g;
    int                 i;
    logic [N-1:0]       oh;
    logic signed [15:0] a;
    logic signed [9:0]  b;
    exp_t               e;
    if (reset !== 1'b1) begin
      ce_exp = !(res_valid && !res_ready);
      chk("mul_ce", mul_ce, ce_exp);
      g = -1;
      if (ce_exp && !drain) begin
        for (int k = 0; k < N; k++) begin
          i = (rr_m + k) % N;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      chk("req_ready", req_ready, oh);
      if (g >= 0) begin
        a      = req_a[16*g +: 16];
        b      = req_b[10*g +: 10];
        e.id   = IDW'(g);
        e.data = a * b;
        sb.push_back(e);
        gnt_log.push_back(g);
        rr_m = (g + 1) % N;
        n_gnt_m++;
      end
    end
  end

  // Result monitor: pops on every transfer, checks hold during stalls.
  logic [25:0]    held_d;
  logic [IDW-1:0] held_id;
  bit             held = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", res_valid, 1'b1);
        chk("stall_data", res_data, held_d);
        chk("stall_id", res_id, held_id);
        held = 1'b0;
      end
      if (res_valid) begin
        if (res_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got id %0d data %0h, expected no result", res_id, res_data);
          end else begin
            e = sb.pop_front();
            chk("res_id", res_id, e.id);
            chk("res_data", res_data, e.data);
          end
        end else begin
          held    = 1'b1;
          held_d  = res_data;
          held_id = res_id;
        end
      end
    end
  end

  // idle must be high exactly when nothing granted is still outstanding.
  always @(posedge clk) begin
    #2;
    if (reset !== 1'b1) chk("idle", idle, sb.size() == 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [9:0] b);
    req_a[16*i +: 16] = a;
    req_b[10*i +: 10] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 10'($urandom));
  endtask

  task automatic send_one(input int i, input logic [15:0] a, input logic [9:0] b,
                          input logic [25:0] exp);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    req_valid = oh;
    set_op(i, a, b);
    #1;
    chk("single_grant", req_ready, oh);
    step();
    req_valid = '0;
    chk("lat1_valid", res_valid, 1'b0);
    step();
    chk("lat2_valid", res_valid, 1'b1);
    chk("direct_data", res_data, exp);
    chk("direct_id", res_id, i);
    step();
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (idle && sb.size() == 0) break;
      step();
    end
    chk("wait_idle", idle, 1'b1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] oh;
    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    drain     = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_mul_ce", mul_ce, 1'b1);
    chk("rst_res_id", res_id, '0);
    chk("rst_din0", mul_din0, '0);
    chk("rst_din1", mul_din1, '0);
    chk("rst_stat_grants", stat_grants, '0);
    chk("rst_stat_stalls", stat_stalls, '0);
    req_valid = '0;
    reset     = 1'b0;
    step();

    // Directed products, including sign extremes; ends with rr back at 0.
    send_one(1, 16'h7FFF, 10'h1FF, 26'h0FF7E01);
    send_one(2, 16'h8000, 10'h200, 26'h1000000);
    send_one(3, 16'hFFFF, 10'h001, 26'h3FFFFFF);

    // Fairness: all requesters valid for 8 cycles.
    gnt_log.delete();
    req_valid = '1;
    repeat (8) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    chk("fair_count", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("fair_order", gnt_log[k], k % N);
    wait_idle(6);

    // Back-pressure: 5 stalled cycles in the middle of a full stream.
    req_valid = '1;
    repeat (4) begin
      rand_ops();
      step();
    end
    res_ready = 1'b0;
    repeat (5) begin
      rand_ops();
      #1;
      chk("bp_mul_ce", mul_ce, 1'b0);
      chk("bp_req_ready", req_ready, '0);
      step();
    end
    res_ready = 1'b1;
`ifdef NETWORK_MUL_SHARE_STATS_EN
    chk("stat_stalls", stat_stalls, 32'd5);
`else
    chk("stat_stalls_tied", stat_stalls, 32'd0);
`endif
    repeat (3) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    wait_idle(6);

    // Drain with two results in flight, then release.
    req_valid = '1;
    rand_ops();
    step();
    rand_ops();
    step();
    drain = 1'b1;
    #1;
    chk("drain_ready", req_ready, '0);
    chk("drain_busy", idle, 1'b0);
    wait_idle(4);
    drain = 1'b0;
    #1;
    oh = '0;
    oh[rr_m] = 1'b1;
    chk("drain_release", req_ready, oh);
    step();
    req_valid = '0;
    wait_idle(6);

    // Reset while two tags are valid.
    req_valid = '1;
    rand_ops();
    step();
    rand_ops();
    step();
    reset = 1'b1;
    sb.delete();
    rr_m    = 0;
    n_gnt_m = 0;
    #1;
    chk("mrst_res_valid", res_valid, 1'b0);
    chk("mrst_idle", idle, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk("mrst_first_grant", req_ready, 4'b0001);
    repeat (4) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    wait_idle(6);

    // Randomized traffic with back-pressure and drain pulses.
    repeat (400) begin
      req_valid = N'($urandom);
      rand_ops();
      res_ready = ($urandom % 4) != 0;
      drain     = ($urandom % 10) == 0;
      step();
    end
    req_valid = '0;
    drain     = 1'b0;
    res_ready = 1'b1;
    wait_idle(10);
`ifdef NETWORK_MUL_SHARE_STATS_EN
    chk("stat_grants", stat_grants, n_gnt_m);
`else
    chk("stat_grants_tied", stat_grants, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
